// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-bit, M-channel valid/ready multiplexer feeding one
// registered output channel. Arbitration is fixed priority (RR_MODE=0,
// lowest index wins) or round-robin (RR_MODE=1, search from a pointer that
// advances past the last winner).
//
// Optional packet locking: define MUX_ARB_LOCK_EN to add in_last/out_last.
// While a multi-beat packet is in progress only its channel can be granted,
// and the round-robin pointer moves only when the packet ends.
module mux_arb_nto1 #(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int RR_MODE = 1,
  parameter int SW      = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M-1:0]   in_valid,
  input  logic [M*N-1:0] in_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [M-1:0]   in_last,
`endif
  output logic [M-1:0]   in_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
`ifdef MUX_ARB_LOCK_EN
  output logic           out_last,
`endif
  input  logic           out_ready
);

  logic [N-1:0]  ch_data [M];
  logic [M-1:0]  req;
  logic [M-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          grant_any;
  logic          load_en;
  logic          handshake;
  logic          pkt_end;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] ptr_next;

  // Unpack the flat data bus into one word per channel.
  for (genvar g = 0; g < M; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*N +: N];
  end

  // The register can take a new word when it is empty or being drained now.
  assign load_en   = !out_valid || out_ready;
  assign handshake = grant_any && load_en;
  assign in_ready  = load_en ? grant : '0;
  assign ptr_next  = (grant_idx == SW'(M - 1)) ? '0 : grant_idx + SW'(1);

`ifdef MUX_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t   lock_state;
  logic [SW-1:0] lock_ch;

  // Restrict eligible requests to the owning channel while a packet is open.
  assign req     = (lock_state == LOCKED) ? (in_valid & (M'(1) << lock_ch)) : in_valid;
  assign pkt_end = in_last[grant_idx];

  // Lock FSM: open on a non-final beat, close on the final beat of the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= IDLE;
      lock_ch    <= '0;
    end else if (handshake) begin
      case (lock_state)
        IDLE: begin
          if (!in_last[grant_idx]) begin
            lock_state <= LOCKED;
            lock_ch    <= grant_idx;
          end
        end
        LOCKED: begin
          if (in_last[grant_idx]) lock_state <= IDLE;
        end
        default: lock_state <= IDLE;
      endcase
    end
  end
`else
  assign req     = in_valid;
  assign pkt_end = 1'b1;
`endif

  // Arbiter: first requesting channel found scanning upward from the start
  // index (0 for fixed priority, the pointer for round-robin), wrapping mod M.
  always_comb begin
    int idx;
    // NOTE: every variable driven here gets a value before any condition, so
    // no path leaves one unassigned and no latch is inferred.
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < M; k++) begin
      idx = (RR_MODE != 0) ? ((int'(rr_ptr) + k) % M) : k;
      if (!grant_any && req[SW'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = SW'(idx);
      end
    end
    grant = grant_any ? (M'(1) << grant_idx) : '0;
  end

  // Round-robin pointer: moves past the winner only when a packet completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if ((RR_MODE != 0) && handshake && pkt_end) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples values from before the edge, independent of statement order.
      rr_ptr <= ptr_next;
    end
  end

  // Output register: load on handshake, empty on drain with nothing pending,
  // otherwise hold (including the whole time the consumer stalls).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
`ifdef MUX_ARB_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (handshake) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[grant_idx];
      out_sel   <= grant_idx;
`ifdef MUX_ARB_LOCK_EN
      out_last  <= in_last[grant_idx];
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: drives a fixed-priority and a round-robin instance from
// shared stimulus; a directed table, hand sequences for reset/locking and a
// random phase are checked against a transaction-level reference model.
module tb_mux_arb_nto1;

  localparam int N = 8;
  localparam int M = 4;
`ifdef MUX_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic [M-1:0]   in_valid;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_last;
  logic           out_ready;

  logic [M-1:0] rdy_fp, rdy_rr;
  logic         ov_fp, ov_rr;
  logic [N-1:0] od_fp, od_rr;
  logic [1:0]   os_fp, os_rr;
`ifdef MUX_ARB_LOCK_EN
  logic         ol_fp, ol_rr;
`endif

  int n_vec = 0;
  int n_err = 0;

  mux_arb_nto1 #(.N(N), .M(M), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef MUX_ARB_LOCK_EN
    .in_last(in_last), .out_last(ol_fp),
`endif
    .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp),
    .out_ready(out_ready)
  );

  mux_arb_nto1 #(.N(N), .M(M), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef MUX_ARB_LOCK_EN
    .in_last(in_last), .out_last(ol_rr),
`endif
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit       ov;
    bit [7:0] od;
    bit [1:0] os;
    bit       ol;
    int       ptr;
    bit       locked;
    int       lch;
  } mstate_t;

  mstate_t m [2];  // [0] fixed priority, [1] round-robin

  function automatic mstate_t mreset();
    mstate_t s;
    s.ov = 0; s.od = 0; s.os = 0; s.ol = 0; s.ptr = 0; s.locked = 0; s.lch = 0;
    return s;
  endfunction

  // Winning channel index, or -1 when nobody is eligible.
  function automatic int winner(mstate_t s, int mode, logic [3:0] v);
    if (s.locked) return v[s.lch] ? s.lch : -1;
    for (int k = 0; k < M; k++) begin
      int i = (mode != 0) ? (s.ptr + k) % M : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(mstate_t s, int mode, logic [3:0] v, logic r);
    int w = winner(s, mode, v);
    if ((!s.ov || r) && w >= 0) return 4'(1 << w);
    return 4'b0000;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int mode, logic [3:0] v,
                                    logic [31:0] d, logic r, logic [3:0] last);
    int w = winner(s, mode, v);
    if ((!s.ov || r) && w >= 0) begin
      s.ov = 1;
      s.od = d[w*8 +: 8];
      s.os = w[1:0];
      s.ol = last[w];
      if (LOCK) begin
        if (!s.locked && !last[w]) begin
          s.locked = 1;
          s.lch    = w;
        end else if (s.locked && last[w]) begin
          s.locked = 0;
        end
      end
      if (mode != 0 && (!LOCK || last[w])) s.ptr = (w + 1) % M;
    end else if (s.ov && r) begin
      s.ov = 0;
    end
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    check("ov_fp", 64'(ov_fp), 64'(m[0].ov));
    check("od_fp", 64'(od_fp), 64'(m[0].od));
    check("os_fp", 64'(os_fp), 64'(m[0].os));
    check("ov_rr", 64'(ov_rr), 64'(m[1].ov));
    check("od_rr", 64'(od_rr), 64'(m[1].od));
    check("os_rr", 64'(os_rr), 64'(m[1].os));
`ifdef MUX_ARB_LOCK_EN
    check("ol_fp", 64'(ol_fp), 64'(m[0].ol));
    check("ol_rr", 64'(ol_rr), 64'(m[1].ol));
`endif
  endtask

  // One cycle: drive after a falling edge, check ready, clock, check registers.
  task automatic step(logic [3:0] v, logic [31:0] d, logic r, logic [3:0] last);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    in_last   = last;
    #1;
    check("rdy_fp", 64'(rdy_fp), 64'(exp_rdy(m[0], 0, v, r)));
    check("rdy_rr", 64'(rdy_rr), 64'(exp_rdy(m[1], 1, v, r)));
    @(posedge clk);
    m[0] = mstep(m[0], 0, v, d, r, last);
    m[1] = mstep(m[1], 1, v, d, r, last);
    @(negedge clk);
    check_regs();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    m[0] = mreset();
    m[1] = mreset();
    check("arst_ov_fp", 64'(ov_fp), 64'(0));
    check("arst_od_fp", 64'(od_fp), 64'(0));
    check("arst_ov_rr", 64'(ov_rr), 64'(0));
    check("arst_od_rr", 64'(od_rr), 64'(0));
    check("arst_os_rr", 64'(os_rr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    logic        e_ov;
    logic [1:0]  e_fsel;
    logic [7:0]  e_fdat;
    logic [1:0]  e_rsel;
    logic [7:0]  e_rdat;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [3:0] rv;
    logic [3:0] rl;

    // idle after reset release
    tbl[0]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 8'h00};
    tbl[1]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 8'h00};
    // ch1 vs ch3: fixed priority keeps ch1, round-robin alternates
    tbl[2]  = '{4'b1010, 32'h3322_1100, 1'b1, 1'b1, 2'd1, 8'h11, 2'd1, 8'h11};
    tbl[3]  = '{4'b1010, 32'h3322_1100, 1'b1, 1'b1, 2'd1, 8'h11, 2'd3, 8'h33};
    tbl[4]  = '{4'b1000, 32'h3322_1100, 1'b1, 1'b1, 2'd3, 8'h33, 2'd3, 8'h33};
    // all valid: round-robin 0,1,2,3,0
    tbl[5]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b1, 2'd0, 8'h11, 2'd0, 8'h11};
    tbl[6]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b1, 2'd0, 8'h11, 2'd1, 8'h22};
    tbl[7]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b1, 2'd0, 8'h11, 2'd2, 8'h33};
    tbl[8]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b1, 2'd0, 8'h11, 2'd3, 8'h44};
    tbl[9]  = '{4'b1111, 32'h4433_2211, 1'b1, 1'b1, 2'd0, 8'h11, 2'd0, 8'h11};
    // load 0xA5 then stall five cycles with ch1/ch2 pending
    tbl[10] = '{4'b0001, 32'h0000_00A5, 1'b1, 1'b1, 2'd0, 8'hA5, 2'd0, 8'hA5};
    tbl[11] = '{4'b0110, 32'h00C2_B100, 1'b0, 1'b1, 2'd0, 8'hA5, 2'd0, 8'hA5};
    tbl[12] = '{4'b0110, 32'h00C2_B100, 1'b0, 1'b1, 2'd0, 8'hA5, 2'd0, 8'hA5};
    tbl[13] = '{4'b0110, 32'h00C2_B100, 1'b0, 1'b1, 2'd0, 8'hA5, 2'd0, 8'hA5};
    tbl[14] = '{4'b0110, 32'h00C2_B100, 1'b0, 1'b1, 2'd0, 8'hA5, 2'd0, 8'hA5};
    tbl[15] = '{4'b0110, 32'h00C2_B100, 1'b0, 1'b1, 2'd0, 8'hA5, 2'd0, 8'hA5};
    tbl[16] = '{4'b0110, 32'h00C2_B100, 1'b1, 1'b1, 2'd1, 8'hB1, 2'd1, 8'hB1};
    // single ch2 transfer then drain; data/sel hold, pointer left at 3
    tbl[17] = '{4'b0100, 32'h005C_0000, 1'b1, 1'b1, 2'd2, 8'h5C, 2'd2, 8'h5C};
    tbl[18] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd2, 8'h5C, 2'd2, 8'h5C};
    tbl[19] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd2, 8'h5C, 2'd2, 8'h5C};
    tbl[20] = '{4'b1111, 32'h4433_2211, 1'b1, 1'b1, 2'd0, 8'h11, 2'd3, 8'h44};

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '1;
    out_ready = 1'b0;
    m[0] = mreset();
    m[1] = mreset();

    #12;
    check("rst_ov_fp",  64'(ov_fp),  64'(0));
    check("rst_od_fp",  64'(od_fp),  64'(0));
    check("rst_os_fp",  64'(os_fp),  64'(0));
    check("rst_rdy_fp", 64'(rdy_fp), 64'(0));
    check("rst_ov_rr",  64'(ov_rr),  64'(0));
    check("rst_rdy_rr", 64'(rdy_rr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, 4'hF);
      check($sformatf("tbl%0d_ov_fp", i), 64'(ov_fp), 64'(tbl[i].e_ov));
      check($sformatf("tbl%0d_os_fp", i), 64'(os_fp), 64'(tbl[i].e_fsel));
      check($sformatf("tbl%0d_od_fp", i), 64'(od_fp), 64'(tbl[i].e_fdat));
      check($sformatf("tbl%0d_ov_rr", i), 64'(ov_rr), 64'(tbl[i].e_ov));
      check($sformatf("tbl%0d_os_rr", i), 64'(os_rr), 64'(tbl[i].e_rsel));
      check($sformatf("tbl%0d_od_rr", i), 64'(od_rr), 64'(tbl[i].e_rdat));
      if (i >= 11 && i <= 15) begin
        check($sformatf("tbl%0d_stall_rdy_fp", i), 64'(rdy_fp), 64'(0));
        check($sformatf("tbl%0d_stall_rdy_rr", i), 64'(rdy_rr), 64'(0));
      end
    end

    // asynchronous reset in the middle of a busy stream
    step(4'b1111, 32'h4433_2211, 1'b1, 4'hF);
    async_reset();
    step(4'b0000, 32'h0, 1'b1, 4'hF);
    check("post_arst_ov_rr", 64'(ov_rr), 64'(0));

`ifdef MUX_ARB_LOCK_EN
    // 3-beat packet on ch0 with ch1 valid throughout; a ch0 gap stalls output
    step(4'b0011, 32'h0000_B0A0, 1'b1, 4'b0000);
    check("lk_b1_sel", 64'(os_rr), 64'(0));
    step(4'b0010, 32'h0000_B000, 1'b1, 4'b0000);
    check("lk_gap_ov_rr", 64'(ov_rr), 64'(0));
    check("lk_gap_ov_fp", 64'(ov_fp), 64'(0));
    step(4'b0011, 32'h0000_B0A1, 1'b1, 4'b0000);
    check("lk_b2_dat", 64'(od_rr), 64'(8'hA1));
    step(4'b0011, 32'h0000_B0A2, 1'b1, 4'b0001);
    check("lk_b3_last", 64'(ol_rr), 64'(1));
    step(4'b0010, 32'h0000_B000, 1'b1, 4'b0010);
    check("lk_ch1_sel", 64'(os_rr), 64'(1));
    // reset mid-packet releases the lock
    step(4'b0001, 32'h0000_00A7, 1'b1, 4'b0000);
    async_reset();
    step(4'b0010, 32'h0000_C100, 1'b1, 4'b0010);
    check("lk_rst_sel_fp", 64'(os_fp), 64'(1));
    check("lk_rst_ov_fp",  64'(ov_fp), 64'(1));
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rv = 4'($urandom);
      rl = LOCK ? 4'($urandom) : 4'hF;
      step(rv, $urandom, ($urandom_range(0, 3) != 0), rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
Parametrised N-to-1 data multiplexer that selects among M valid/ready input channels and drives one registered output channel. It is the successor to the combinational 2:1 mux. It adds per-channel handshakes, an arbiter with fixed-priority or round-robin mode, and one output pipeline register. It sits between multiple producer blocks and a single shared consumer on the clk domain.

Parameters:
N, 8, data width per channel in bits (N >= 1)
M, 4, number of input channels (M >= 2)
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
SW, $clog2(M), width of the channel index (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  M  per-channel valid; bit i belongs to channel i
in_data  input  M*N  packed channel data; channel i occupies bits [i*N +: N]
in_ready  output  M  per-channel ready; at most one bit high per cycle
out_valid  output  1  output register holds valid data
out_data  output  N  registered selected data
out_sel  output  SW  index of the channel that produced out_data
out_ready  input  1  consumer accepts out_data when out_valid && out_ready

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, RR pointer=0, lock state=IDLE. Reset is honoured mid-transfer; any data in flight is dropped.
- load_en = !out_valid || out_ready. The output register loads only when load_en is high and at least one in_valid bit is set.
- Arbitration is combinational over in_valid and produces a one-hot grant.
  - RR_MODE=0: the lowest set index wins.
  - RR_MODE=1: search starts at the RR pointer and wraps modulo M; the first set index at or after the pointer wins.
- in_ready[i] = grant[i] && load_en. Handshake on channel i is in_valid[i] && in_ready[i].
- On a handshake from channel g:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - If RR_MODE=1, the pointer becomes (g+1) mod M; it wraps from M-1 to 0.
- If out_valid && out_ready and no input is valid, out_valid <= 0 and out_data/out_sel hold their values.
- While out_valid && !out_ready, out_data, out_sel and out_valid are stable and all in_ready are low.
- Latency: one cycle from input handshake to out_valid. Throughput is one transfer per cycle while out_ready stays high.
- Simultaneous drain and load (out_valid && out_ready with a pending request): the register is replaced in the same cycle with no bubble.
- in_valid may drop without a handshake; the arbiter re-evaluates each cycle with no grant memory beyond the RR pointer (and lock state, if enabled).
- The RR pointer advances only on a handshake, never on idle or stall cycles.

Optional Feature:
MUX_ARB_LOCK_EN:
- Defined: adds input in_last (M bits, per-channel end-of-packet). Lock FSM states:
  - IDLE: normal arbitration. A handshake from channel g with in_last[g]=0 moves to LOCKED(g).
  - LOCKED(g): only channel g may be granted, even if others are valid. A handshake with in_last[g]=1 returns to IDLE.
  - The RR pointer is updated only on the handshake that returns to IDLE.
  - Reset forces IDLE.
  - Adds output out_last, registered alongside out_data; its reset value is 0.
- Undefined: no in_last or out_last ports. Every transfer is an independent single-beat arbitration.

Test Plan:
1. Reset check: rst_n low -> out_valid=0, out_data=0, out_sel=0, in_ready=0000. Release rst_n with in_valid=0 -> outputs unchanged.
2. Fixed priority: RR_MODE=0, in_valid=1010, ch1=0x11, ch3=0x33, out_ready=1 -> next cycle out_data=0x11, out_sel=1. Ch3 is served only after ch1 drops valid.
3. Round-robin fairness: RR_MODE=1, in_valid=1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
4. Backpressure: out_valid=1 with data 0xA5, out_ready=0 for 5 cycles while in_valid=0110 -> out_data stays 0xA5 and in_ready=0000 throughout. When out_ready rises, the next channel loads the same cycle.
5. Drain to empty: single transfer from ch2 with data 0x5C, then in_valid=0 and out_ready=1 -> out_valid falls one cycle after acceptance, RR pointer stays 3.
6. Async reset mid-stream (and, with MUX_ARB_LOCK_EN, mid-packet):
   - Without the macro: assert rst_n low between clock edges -> outputs clear immediately.
   - With MUX_ARB_LOCK_EN: a 3-beat packet on ch0 blocks a valid ch1 until the beat with in_last[0]=1; reset during the packet returns the FSM to IDLE.
